// File: rtl/pend_arbiter_if.sv
// Bus between the pending-interrupt arbiter (master) and the peripheral/CLIC entry side (slave).
interface pend_arbiter_if #(
  parameter int VecSize   = 8,
  parameter int PrioWidth = 3
);
  localparam int IW = (VecSize > 1) ? $clog2(VecSize) : 1;
  localparam int EW = PrioWidth + 2;

  logic [VecSize-1:0] irq_req;
  logic               csr_busy;
  logic [IW-1:0]      entry_rd_idx;
  logic [EW-1:0]      entry_rd_data;
  logic               entry_we;
  logic [IW-1:0]      entry_wr_idx;
  logic [EW-1:0]      entry_wr_data;
  logic               busy;
  logic [7:0]         overrun_cnt;

  modport master (
    input  irq_req, csr_busy, entry_rd_data,
    output entry_rd_idx, entry_we, entry_wr_idx, entry_wr_data, busy, overrun_cnt
  );

  modport slave (
    output irq_req, csr_busy, entry_rd_data,
    input  entry_rd_idx, entry_we, entry_wr_idx, entry_wr_data, busy, overrun_cnt
  );
endinterface

// File: rtl/pend_arbiter.sv
// Round-robin arbiter that sets the pended bit of interrupt entries via read-modify-write.
// Optional coalesced-request counter enabled by macro PEND_ARBITER_OVERRUN_EN.
//
// state | meaning
// IDLE  | waiting for a pending request and a free CSR port
// READ  | entry[sel] presented on the read port, captured at end of cycle
// WRITE | write cap|pended back unless the CPU owns the CSR this cycle
module pend_arbiter #(
  parameter int VecSize   = 8,
  parameter int PrioWidth = 3
) (
  input logic clk,
  input logic reset,
  pend_arbiter_if.master bus
);
  localparam int IW = (VecSize > 1) ? $clog2(VecSize) : 1;
  localparam int EW = PrioWidth + 2;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e             state_q;
  logic [VecSize-1:0] req_q, req_d;
  logic [VecSize-1:0] hist_q;
  logic               hist_vld_q;
  logic [IW-1:0]      sel_q, last_q, rd_idx_q;
  logic [EW-1:0]      cap_q;
  logic               busy_q;

  logic [VecSize-1:0] rise, clr_mask, coalesce;
  logic               commit;
  logic               pick_vld;
  logic [IW-1:0]      pick;
  int                 idx;

  // The first clock after reset only loads history, so a line held high is not an edge.
  assign rise     = hist_vld_q ? (bus.irq_req & ~hist_q) : '0;
  assign commit   = (state_q == WRITE) && !bus.csr_busy;
  assign coalesce = rise & req_q & ~clr_mask;

  always_comb begin
    clr_mask = '0;
    if (commit) clr_mask[sel_q] = 1'b1;
    req_d = (req_q & ~clr_mask) | rise;
  end

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int i = 1; i <= VecSize; i++) begin
      idx = (int'(last_q) + i) % VecSize;
      if (!pick_vld && req_q[idx]) begin
        pick_vld = 1'b1;
        pick     = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
      sel_q      <= '0;
      cap_q      <= '0;
      last_q     <= IW'(VecSize - 1);
      rd_idx_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      hist_q     <= bus.irq_req;
      hist_vld_q <= 1'b1;
      req_q      <= req_d;
      case (state_q)
        IDLE: begin
          if (pick_vld && !bus.csr_busy) begin
            sel_q    <= pick;
            rd_idx_q <= pick;
            busy_q   <= 1'b1;
            state_q  <= READ;
          end
        end
        READ: begin
          cap_q    <= bus.entry_rd_data;
          rd_idx_q <= '0;
          state_q  <= WRITE;
        end
        WRITE: begin
          if (commit) begin
            last_q  <= sel_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rd_idx_q <= sel_q;
            state_q  <= READ;
          end
        end
        default: begin
          rd_idx_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.entry_rd_idx  = rd_idx_q;
  assign bus.busy          = busy_q;
  assign bus.entry_we      = commit;
  assign bus.entry_wr_idx  = commit ? sel_q : '0;
  assign bus.entry_wr_data = commit ? (cap_q | EW'(1)) : '0;

`ifdef PEND_ARBITER_OVERRUN_EN
  logic [7:0] ovr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr_q <= '0;
    end else if ((|coalesce) && (ovr_q != 8'hFF)) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end

  assign bus.overrun_cnt = ovr_q;
`else
  logic unused_coalesce;
  assign unused_coalesce = |coalesce;
  assign bus.overrun_cnt = '0;
`endif
endmodule

// File: doc/pend_arbiter.md
PEND_ARBITER -- requirements
Module: pend_arbiter

Interface
REQ-001 SHALL have parameter VecSize, default 8, number of interrupt vectors / requesters.
REQ-002 SHALL have parameter PrioWidth, default 3, priority field width; entry width EW = PrioWidth+2 (prio, enabled, pended=LSB).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port irq_req  input  VecSize  per-vector peripheral interrupt lines, level, synchronous to clk.
REQ-006 SHALL have port csr_busy  input  1  CPU CSR access to an entry CSR this cycle; arbiter must not write.
REQ-007 SHALL have port entry_rd_idx  output  $clog2(VecSize)  entry index for combinational read.
REQ-008 SHALL have port entry_rd_data  input  EW  current value of entry[entry_rd_idx].
REQ-009 SHALL have port entry_we  output  1  one-cycle write strobe to the entry CSR external write port.
REQ-010 SHALL have port entry_wr_idx  output  $clog2(VecSize)  target entry of the write.
REQ-011 SHALL have port entry_wr_data  output  EW  value to write.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-013 SHALL have port overrun_cnt  output  8  saturating coalesced-request count (see Configuration).

Function
REQ-014 SHALL detect rising edges of each irq_req bit against a registered copy and set sticky bit req_q[k] on the edge that samples the rise.
REQ-015 SHALL implement FSM IDLE -> READ -> WRITE -> IDLE, one state per cycle.
REQ-016 IDLE: if req_q != 0 and csr_busy == 0, SHALL latch sel = first set bit of req_q searching round-robin from last_grant+1 (wrap VecSize-1 -> 0) and go READ; otherwise stay IDLE.
REQ-017 READ: SHALL drive entry_rd_idx = sel, register entry_rd_data into cap, go WRITE.
REQ-018 WRITE with csr_busy == 0: SHALL assert entry_we for exactly one cycle with entry_wr_idx = sel, entry_wr_data = cap with bit 0 set, clear req_q[sel], set last_grant = sel, go IDLE.
REQ-019 WRITE with csr_busy == 1: SHALL NOT assert entry_we and SHALL return to READ (re-read, discard cap), keeping sel.
REQ-020 Unstalled latency: entry_we SHALL assert in the third cycle after the edge setting req_q (edge t: req_q set; t+1 READ; t+2 WRITE, entry_we high; commit at t+3).
REQ-021 A new rising edge on irq_req[sel] in the same cycle as its clear SHALL win: req_q[sel] remains set.
REQ-022 A rising edge on a vector whose req_q is already set SHALL coalesce (no second write).
REQ-023 The write SHALL be performed even if cap already has pended = 1 or enabled = 0; gating belongs to the CLIC.
REQ-024 entry_rd_idx SHALL equal sel in READ and 0 otherwise; entry_wr_idx/entry_wr_data SHALL be 0 when entry_we == 0.
REQ-025 At most one entry write SHALL occur per 3 cycles; no requester SHALL wait more than VecSize grants once set.

Reset
REQ-026 reset low SHALL asynchronously force: state IDLE, req_q 0, irq_req history 0, sel 0, cap 0, last_grant VecSize-1, entry_we 0, entry_rd_idx 0, entry_wr_idx 0, entry_wr_data 0, busy 0, overrun_cnt 0.
REQ-027 Reset mid-transaction SHALL abandon the pending write; no entry_we SHALL be emitted during or in the first cycle after reset.
REQ-028 irq_req held high through reset release SHALL NOT be seen as a rising edge (history reset to 0 then sampled: edge counts only if line was low after release... history samples irq_req on the first clock after release with no edge).

Configuration
REQ-029 Macro PEND_ARBITER_OVERRUN_EN: when defined, overrun_cnt SHALL increment by 1 on each coalesced edge (REQ-022), multiple in one cycle counting as 1, saturating at 255.
REQ-030 Without PEND_ARBITER_OVERRUN_EN, overrun_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-031 irq_req[2] 0->1 at edge t, csr_busy 0, entry[2]=5'b10110 -> entry_we at t+2 cycle, idx 2, data 5'b10111, busy low at t+3.
REQ-032 irq_req[1],[5],[6] rise same cycle -> writes in order 1,5,6, spaced 3 cycles; then irq_req[0],[6] rise, last_grant 6 -> order 0,6.
REQ-033 csr_busy high during WRITE for 2 cycles -> no entry_we, FSM cycles READ/WRITE, write issued first WRITE with csr_busy 0 using freshly read data.
REQ-034 irq_req[3] pulses twice while req_q[3] set, OVERRUN_EN defined -> single write to entry 3, overrun_cnt = 2; without macro overrun_cnt = 0.
REQ-035 reset asserted in WRITE state -> entry_we never asserted, all outputs 0, req_q cleared; irq_req held high across release -> no write.
